bip2_control_unit: RTL and testbench

- Multi-cycle controller for the BIP-2 datapath.
- Owns the program counter (PC), instruction register (IR) and status flags (Z, N).
- Sequences fetch/execute and drives the accumulator write enable, the 3-way accumulator-input mux select, the ALU operand select and op, and the data-RAM write.
- Sits between program memory and the ACC/ALU/data-RAM datapath.

---
 rtl/bip2_pkg.sv | 64 ++++++
 rtl/bip2_decoder.sv | 29 ++
 rtl/bip2_control_unit.sv | 90 +++++++++
 tb/tb_bip2_control_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip2_pkg.sv
// Shared definitions for the BIP-2 control path: opcodes, mux encodings,
// FSM state codes and the decoded control bundle.
package bip2_pkg;

    localparam int DATA_W  = 11;
    localparam int OP_W    = 5;
    localparam int INSTR_W = OP_W + DATA_W;

    localparam logic [OP_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OP_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OP_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OP_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OP_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OP_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OP_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OP_W-1:0] OPC_SUBI = 5'b00111;
    localparam logic [OP_W-1:0] OPC_BEQ  = 5'b01000;
    localparam logic [OP_W-1:0] OPC_BNE  = 5'b01001;
    localparam logic [OP_W-1:0] OPC_BGT  = 5'b01010;
    localparam logic [OP_W-1:0] OPC_BGE  = 5'b01011;
    localparam logic [OP_W-1:0] OPC_BLT  = 5'b01100;
    localparam logic [OP_W-1:0] OPC_BLE  = 5'b01101;
    localparam logic [OP_W-1:0] OPC_JMP  = 5'b01110;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef struct packed {
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_ram;
        logic       is_branch;
        logic       flag_upd;
        logic       is_hlt;
    } ctrl_t;

    // Flags passed in are the ones held before the branch executes.
    function automatic logic branch_cond(input logic [OP_W-1:0] opc,
                                         input logic z, input logic n);
        case (opc)
            OPC_BEQ: return z;
            OPC_BNE: return !z;
            OPC_BGT: return !z && !n;
            OPC_BGE: return !n;
            OPC_BLT: return n;
            OPC_BLE: return n || z;
            OPC_JMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bip2_decoder.sv
// Pure combinational opcode decode into the datapath control bundle.
module bip2_decoder
    import bip2_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_HLT:  ctrl.is_hlt = 1'b1;
            OPC_STO:  ctrl.wr_ram = 1'b1;
            OPC_LD:   begin ctrl.wr_acc = 1'b1; ctrl.sel_a = SELA_RAM; end
            OPC_LDI:  begin ctrl.wr_acc = 1'b1; ctrl.sel_a = SELA_IMM; end
            OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI: begin
                ctrl.wr_acc   = 1'b1;
                ctrl.sel_a    = SELA_ALU;
                ctrl.sel_b    = opcode[0];
                ctrl.op       = opcode[1] ? ALU_SUB : ALU_ADD;
                ctrl.flag_upd = 1'b1;
            end
            OPC_BEQ, OPC_BNE, OPC_BGT, OPC_BGE, OPC_BLT, OPC_BLE, OPC_JMP:
                ctrl.is_branch = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/bip2_control_unit.sv
// BIP-2 multi-cycle controller: FETCH/EXEC/HALT sequencing with PC, IR and
// Z/N flags. Controls are decoded at fetch and registered for the EXEC cycle.
module bip2_control_unit
    import bip2_pkg::*;
(
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               alu_z_i,
    input  logic               alu_n_i,
    output logic [DATA_W-1:0]  pc_o,
    output logic [DATA_W-1:0]  operand_o,
    output logic               WrAcc_o,
    output logic [1:0]         SelA_o,
    output logic               SelB_o,
    output logic               Op_o,
    output logic               WrRam_o,
    output logic               halted_o,
    output logic [1:0]         state_o
);

    state_t              state;
    logic [DATA_W-1:0]   pc;
    logic [INSTR_W-1:0]  ir;
    logic                flag_z, flag_n;
    logic                halted;
    ctrl_t               dec, ctrl_q;
    logic [OP_W-1:0]     ir_opc;

    assign ir_opc = ir[INSTR_W-1 -: OP_W];

    bip2_decoder u_dec (
        .opcode (instr_i[INSTR_W-1 -: OP_W]),
        .ctrl   (dec)
    );

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            halted <= 1'b0;
            ctrl_q <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    ir     <= instr_i;
                    ctrl_q <= dec;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    ctrl_q <= '0;
                    if (ctrl_q.flag_upd) begin
                        flag_z <= alu_z_i;
                        flag_n <= alu_n_i;
                    end
                    if (ctrl_q.is_hlt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        // Condition sees pre-instruction flags; PC wraps naturally.
                        if (ctrl_q.is_branch && branch_cond(ir_opc, flag_z, flag_n))
                            pc <= ir[DATA_W-1:0];
                        else
                            pc <= pc + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: begin
                    ctrl_q <= '0;
                    state  <= ST_FETCH;
                end
            endcase
        end
    end

    assign pc_o      = pc;
    assign operand_o = ir[DATA_W-1:0];
    assign WrAcc_o   = ctrl_q.wr_acc;
    assign SelA_o    = ctrl_q.sel_a;
    assign SelB_o    = ctrl_q.sel_b;
    assign Op_o      = ctrl_q.op;
    assign WrRam_o   = ctrl_q.wr_ram;
    assign halted_o  = halted;
    assign state_o   = state;

endmodule

// File: tb/tb_bip2_control_unit.sv
// Self-checking bench for bip2_control_unit: directed programs plus random
// instruction streams checked against an instruction-level reference model.
module tb_bip2_control_unit;

    logic        clock_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [15:0] instr_i;
    logic        alu_z_i = 1'b0, alu_n_i = 1'b0;
    logic [10:0] pc_o, operand_o;
    logic        WrAcc_o, SelB_o, Op_o, WrRam_o, halted_o;
    logic [1:0]  SelA_o, state_o;
    logic [5:0]  ctrl_bus;

    logic [15:0] imem   [0:2047];
    logic        az_tab [0:2047];
    logic        an_tab [0:2047];

    logic [10:0] m_pc;
    logic        m_z, m_n, m_halt;
    int vectors = 0;
    int miscompares = 0;

    bip2_control_unit dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .instr_i(instr_i),
        .alu_z_i(alu_z_i), .alu_n_i(alu_n_i), .pc_o(pc_o), .operand_o(operand_o),
        .WrAcc_o(WrAcc_o), .SelA_o(SelA_o), .SelB_o(SelB_o), .Op_o(Op_o),
        .WrRam_o(WrRam_o), .halted_o(halted_o), .state_o(state_o)
    );

    always #5 clock_i = ~clock_i;
    assign instr_i  = imem[pc_o];
    assign ctrl_bus = {WrAcc_o, SelA_o, SelB_o, Op_o, WrRam_o};

    function automatic logic [15:0] mk(input logic [4:0] o, input logic [10:0] a);
        return {o, a};
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 2048; a++) begin
            imem[a] = 16'hF800;  // opcode 11111: NOP
            az_tab[a] = 1'b0;
            an_tab[a] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        alu_z_i = 1'b0; alu_n_i = 1'b0;
        m_pc = '0; m_z = 1'b0; m_n = 1'b0; m_halt = 1'b0;
        repeat (3) @(negedge clock_i);
        reset_n_i = 1'b1;
    endtask

    // Executes n instructions on both DUT and model, starting at a FETCH negedge.
    task automatic run_program(input int n_instr);
        logic [15:0] ins;
        logic [4:0]  opc;
        logic [10:0] opr;
        logic [5:0]  exp_c;
        logic        tk;
        for (int i = 0; i < n_instr && !m_halt; i++) begin
            ins = imem[m_pc]; opc = ins[15:11]; opr = ins[10:0];
            alu_z_i = az_tab[m_pc]; alu_n_i = an_tab[m_pc];
            vectors++;
            if (state_o !== 2'b00 || pc_o !== m_pc || ctrl_bus !== 6'b0) begin
                miscompares++;
                $display("FAIL fetch: state=%0d pc=%h ctrl=%b, want state=0 pc=%h ctrl=000000",
                         state_o, pc_o, ctrl_bus, m_pc);
            end
            @(negedge clock_i);
            exp_c = 6'b0; tk = 1'b0;
            case (opc)
                5'd1:  exp_c = 6'b1_00_0_0_0 ^ 6'b1_00_0_0_1; // STO: WrRam only
                5'd2:  exp_c = 6'b1_00_0_0_0;
                5'd3:  exp_c = 6'b1_01_0_0_0;
                5'd4:  exp_c = 6'b1_10_0_0_0;
                5'd5:  exp_c = 6'b1_10_1_0_0;
                5'd6:  exp_c = 6'b1_10_0_1_0;
                5'd7:  exp_c = 6'b1_10_1_1_0;
                5'd8:  tk = m_z;
                5'd9:  tk = !m_z;
                5'd10: tk = !m_z && !m_n;
                5'd11: tk = !m_n;
                5'd12: tk = m_n;
                5'd13: tk = m_n || m_z;
                5'd14: tk = 1'b1;
                default: ;
            endcase
            vectors++;
            if ({state_o, operand_o, ctrl_bus} !== {2'b01, opr, exp_c}) begin
                miscompares++;
                $display("FAIL exec op=%0d: state=%0d operand=%h ctrl=%b, want state=1 operand=%h ctrl=%b",
                         opc, state_o, operand_o, ctrl_bus, opr, exp_c);
            end
            if (opc >= 5'd4 && opc <= 5'd7) begin m_z = alu_z_i; m_n = alu_n_i; end
            if (opc == 5'd0) m_halt = 1'b1;
            else m_pc = tk ? opr : m_pc + 11'd1;
            @(negedge clock_i);
            vectors++;
            if (halted_o !== m_halt || pc_o !== m_pc || state_o !== (m_halt ? 2'b10 : 2'b00)) begin
                miscompares++;
                $display("FAIL post op=%0d: halted=%b pc=%h state=%0d, want halted=%b pc=%h state=%0d",
                         opc, halted_o, pc_o, state_o, m_halt, m_pc, m_halt ? 2 : 0);
            end
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        repeat (3) @(negedge clock_i);
        vectors++;
        if ({pc_o, state_o, ctrl_bus, halted_o} !== {11'h0, 2'b00, 6'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: pc=%h state=%0d ctrl=%b halted=%b, want all zero",
                     pc_o, state_o, ctrl_bus, halted_o);
        end
        clear_mem();
        do_reset();
        vectors++;
        if ({pc_o, state_o, ctrl_bus, halted_o} !== {11'h0, 2'b00, 6'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release: pc=%h state=%0d ctrl=%b halted=%b, want all zero",
                     pc_o, state_o, ctrl_bus, halted_o);
        end
    endtask

    task automatic test_program();
        clear_mem();
        imem[0] = mk(5'd3, 11'd10);
        imem[1] = mk(5'd5, 11'd4);
        imem[2] = mk(5'd1, 11'd5);
        imem[3] = mk(5'd0, 11'd0);
        do_reset();
        run_program(4);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock_i);
            vectors++;
            if (halted_o !== 1'b1 || pc_o !== 11'd3 || ctrl_bus !== 6'b0 || state_o !== 2'b10) begin
                miscompares++;
                $display("FAIL halt_hold: halted=%b pc=%h ctrl=%b state=%0d, want 1 003 000000 2",
                         halted_o, pc_o, ctrl_bus, state_o);
            end
        end
    endtask

    task automatic test_beq_bne();
        for (int v = 0; v < 2; v++) begin
            clear_mem();
            imem[0] = mk(5'd7, 11'd3); az_tab[0] = 1'b1;
            imem[1] = mk(v == 0 ? 5'd8 : 5'd9, 11'h040);
            imem[11'h040] = mk(5'd0, 11'd0);
            imem[2] = mk(5'd0, 11'd0);
            do_reset();
            run_program(3);
            vectors++;
            if (pc_o !== (v == 0 ? 11'h040 : 11'h002)) begin
                miscompares++;
                $display("FAIL %s: pc=%h want %h", v == 0 ? "beq_taken" : "bne_fall",
                         pc_o, v == 0 ? 11'h040 : 11'h002);
            end
        end
    endtask

    task automatic test_neg_branches();
        logic [4:0]  bop [3];
        logic [10:0] tgt [3];
        logic [10:0] want [3];
        bop = '{5'd12, 5'd11, 5'd13};
        tgt = '{11'h100, 11'h200, 11'h300};
        want = '{11'h100, 11'h002, 11'h300};
        for (int k = 0; k < 3; k++) begin
            clear_mem();
            imem[0] = mk(5'd6, 11'd7); an_tab[0] = 1'b1;
            imem[1] = mk(bop[k], tgt[k]);
            imem[2] = mk(5'd0, 11'd0);
            imem[tgt[k]] = mk(5'd0, 11'd0);
            do_reset();
            run_program(3);
            vectors++;
            if (pc_o !== want[k]) begin
                miscompares++;
                $display("FAIL neg_branch op=%0d: pc=%h want %h", bop[k], pc_o, want[k]);
            end
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        imem[0] = mk(5'd14, 11'h7FF);
        imem[11'h7FF] = mk(5'd31, 11'h123);
        do_reset();
        run_program(2);
        vectors++;
        if (pc_o !== 11'h000 || state_o !== 2'b00) begin
            miscompares++;
            $display("FAIL pc_wrap: pc=%h state=%0d want 000 0", pc_o, state_o);
        end
    endtask

    task automatic test_ld_flags();
        clear_mem();
        imem[0] = mk(5'd6, 11'd1); az_tab[0] = 1'b1;
        imem[1] = mk(5'd2, 11'd2); an_tab[1] = 1'b1;  // ALU noise must be ignored
        imem[2] = mk(5'd8, 11'h010);
        imem[3] = mk(5'd0, 11'd0);
        imem[11'h010] = mk(5'd0, 11'd0);
        do_reset();
        run_program(4);
        vectors++;
        if (pc_o !== 11'h010 || halted_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ld_keeps_flags: pc=%h halted=%b want 010 1", pc_o, halted_o);
        end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        imem[2] = mk(5'd4, 11'd9);
        do_reset();
        run_program(2);
        @(negedge clock_i);
        vectors++;
        if (WrAcc_o !== 1'b1 || pc_o !== 11'd2) begin
            miscompares++;
            $display("FAIL mid_pre: wracc=%b pc=%h want 1 002", WrAcc_o, pc_o);
        end
        #2 reset_n_i = 1'b0;
        #1;
        vectors++;
        if (ctrl_bus !== 6'b0 || pc_o !== 11'd0 || state_o !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset: ctrl=%b pc=%h state=%0d want 000000 000 0",
                     ctrl_bus, pc_o, state_o);
        end
        @(negedge clock_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_random();
        clear_mem();
        for (int a = 0; a < 2048; a++) begin
            imem[a] = {5'($urandom_range(1, 31)), 11'($urandom)};
            az_tab[a] = 1'($urandom);
            an_tab[a] = 1'($urandom);
        end
        do_reset();
        run_program(300);
    endtask

    initial begin
        test_reset();
        test_program();
        test_beq_bne();
        test_neg_branches();
        test_wrap();
        test_ld_flags();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
